// File: rtl/simon_pad_pkg.sv
// ============================================================================
// Module  : simon_pad_pkg
// Brief   : Shared pad constants, lamp FSM state encoding and pad index helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package simon_pad_pkg;

  localparam int NUM_PADS  = 4;
  localparam int PAD_IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_ECHO = 2'd2,
    ST_OVER = 2'd3
  } lamp_state_e;

  function automatic logic [NUM_PADS-1:0] pad_onehot(input logic [PAD_IDX_W-1:0] idx);
    logic [NUM_PADS-1:0] w_vec;
    w_vec      = '0;
    w_vec[idx] = 1'b1;
    return w_vec;
  endfunction

  // Highest set bit wins; callers only pass one-hot vectors.
  function automatic logic [PAD_IDX_W-1:0] pad_encode(input logic [NUM_PADS-1:0] vec);
    logic [PAD_IDX_W-1:0] w_idx;
    w_idx = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (vec[i]) w_idx = PAD_IDX_W'(i);
    end
    return w_idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/simon_debounce.sv
// ============================================================================
// Module  : simon_debounce
// Brief   : Two-flop synchroniser plus consecutive-sample debouncer for one button.
// Revision: 1.0
// ============================================================================
`default_nettype none

module simon_debounce #(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_stable
);

  localparam int c_CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE_TICKS - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the stable state restarts the run.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

`default_nettype wire

// File: rtl/simon_pad.sv
// ============================================================================
// Module  : simon_pad
// Brief   : Player pad front end: debounce, arm, accept/encode presses, drive lamps.
// Revision: 1.0
// ============================================================================
`default_nettype none

module simon_pad
  import simon_pad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int ECHO_TICKS     = 15,
  parameter int BLINK_TICKS    = 30
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PADS-1:0]  btn,
  input  logic                 simonTurn,
  input  logic [PAD_IDX_W-1:0] simonNum,
  input  logic                 simonPressed,
  input  logic                 gameOver,
  output logic [PAD_IDX_W-1:0] playerNum,
  output logic                 playerPressed,
  output logic [NUM_PADS-1:0]  lamp,
  output logic                 accepting
);

  localparam int c_SETTLE   = 2 + DEBOUNCE_TICKS;
  localparam int c_SETTLE_W = $clog2(c_SETTLE + 1);
  localparam int c_ECHO_W   = $clog2(ECHO_TICKS + 1);
  localparam int c_BLINK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_TICKS - 1);

  logic [NUM_PADS-1:0]   w_deb;
  logic [NUM_PADS-1:0]   r_prev;
  logic [NUM_PADS-1:0]   w_rise;
  logic [PAD_IDX_W-1:0]  w_rise_idx;
  logic                  w_accept;
  logic [c_SETTLE_W-1:0] r_settle;
  logic                  w_settled;
  logic                  r_armed;
  logic                  r_accepting;
  logic [PAD_IDX_W-1:0]  r_player_num;
  logic                  r_player_pressed;

  lamp_state_e           r_state;
  lamp_state_e           w_state_next;
  logic [NUM_PADS-1:0]   r_lamp;
  logic [NUM_PADS-1:0]   w_lamp_next;
  logic [c_ECHO_W-1:0]   r_echo;
  logic [c_ECHO_W-1:0]   w_echo_next;
  logic [c_BLINK_W-1:0]  r_blink;
  logic [c_BLINK_W-1:0]  w_blink_next;

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_deb
    simon_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_btn   (btn[gi]),
      .o_stable(w_deb[gi])
    );
  end

  assign w_rise     = w_deb & ~r_prev;
  assign w_rise_idx = pad_encode(w_rise);
  // Exactly one rising bit and nothing else held down.
  assign w_accept   = r_accepting & $onehot(w_rise) & (w_deb == w_rise);
  // Arming waits for the sync+debounce pipeline to reflect a button held through reset.
  assign w_settled  = (r_settle == c_SETTLE_W'(c_SETTLE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev           <= '0;
      r_settle         <= '0;
      r_armed          <= 1'b0;
      r_accepting      <= 1'b0;
      r_player_num     <= '0;
      r_player_pressed <= 1'b0;
    end else begin
      r_prev <= w_deb;
      if (!w_settled) r_settle <= r_settle + c_SETTLE_W'(1);
      if (w_settled && (w_deb == '0)) r_armed <= 1'b1;
      r_accepting      <= r_armed & ~simonTurn & ~gameOver;
      r_player_pressed <= w_accept;
      if (w_accept) r_player_num <= w_rise_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_lamp  <= '0;
      r_echo  <= '0;
      r_blink <= '0;
    end else begin
      r_state <= w_state_next;
      r_lamp  <= w_lamp_next;
      r_echo  <= w_echo_next;
      r_blink <= w_blink_next;
    end
  end

  always_comb begin
    w_state_next = ST_IDLE;
    w_lamp_next  = '0;
    w_echo_next  = '0;
    w_blink_next = '0;
    if ((r_state == ST_OVER) || gameOver) begin
      w_state_next = ST_OVER;
      if (r_state != ST_OVER) begin
        w_lamp_next = '1;
      end else if (r_blink == c_BLINK_LAST) begin
        w_lamp_next = ~r_lamp;
      end else begin
        w_lamp_next  = r_lamp;
        w_blink_next = r_blink + c_BLINK_W'(1);
      end
    end else if (simonTurn) begin
      w_state_next = ST_SHOW;
      w_lamp_next  = simonPressed ? pad_onehot(simonNum) : '0;
    end else if (w_accept) begin
      w_state_next = ST_ECHO;
      w_lamp_next  = pad_onehot(w_rise_idx);
      w_echo_next  = c_ECHO_W'(ECHO_TICKS);
    end else if ((r_state == ST_ECHO) && (r_echo > c_ECHO_W'(1))) begin
      w_state_next = ST_ECHO;
      w_lamp_next  = r_lamp;
      w_echo_next  = r_echo - c_ECHO_W'(1);
    end
  end

  assign playerNum     = r_player_num;
  assign playerPressed = r_player_pressed;
  assign lamp          = r_lamp;
  assign accepting     = r_accepting;

endmodule

`default_nettype wire

// File: tb/tb_simon_pad.sv
// ============================================================================
// Module  : tb_simon_pad
// Brief   : Directed self-checking bench for simon_pad with hand-computed expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_simon_pad;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn;
  logic       simonTurn;
  logic [1:0] simonNum;
  logic       simonPressed;
  logic       gameOver;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic [3:0] lamp;
  logic       accepting;

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  simon_pad #(
    .DEBOUNCE_TICKS(3),
    .ECHO_TICKS    (15),
    .BLINK_TICKS   (30)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn          (btn),
    .simonTurn    (simonTurn),
    .simonNum     (simonNum),
    .simonPressed (simonPressed),
    .gameOver     (gameOver),
    .playerNum    (playerNum),
    .playerPressed(playerPressed),
    .lamp         (lamp),
    .accepting    (accepting)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_count(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (playerPressed === 1'b1) cnt++;
    end
  endtask

  initial begin
    reset_n = 1'b0; btn = 4'b0000; simonTurn = 1'b0; simonNum = 2'd0;
    simonPressed = 1'b0; gameOver = 1'b0;
    tick(3);
    chk("rst_num", 32'(playerNum), 32'd0);
    chk("rst_pressed", 32'(playerPressed), 32'd0);
    chk("rst_lamp", 32'(lamp), 32'd0);
    chk("rst_accepting", 32'(accepting), 32'd0);
    reset_n = 1'b1;
    tick(10);
    chk("armed_accepting", 32'(accepting), 32'd1);

    // Single press of pad 2: strobe on the 6th edge after the change
    btn = 4'b0100;
    tick(5);
    chk("p2_before", 32'(playerPressed), 32'd0);
    tick(1);
    chk("p2_strobe", 32'(playerPressed), 32'd1);
    chk("p2_num", 32'(playerNum), 32'd2);
    chk("p2_lamp_on", 32'(lamp), 32'h4);
    tick(1);
    chk("p2_one_cycle", 32'(playerPressed), 32'd0);
    tick(3);
    btn = 4'b0000;
    tick(10);
    chk("p2_lamp_last", 32'(lamp), 32'h4);
    tick(1);
    chk("p2_lamp_off", 32'(lamp), 32'h0);
    chk("p2_num_held", 32'(playerNum), 32'd2);

    // Glitch rejection and minimum-length pulse
    btn = 4'b0001;
    tick(2);
    btn = 4'b0000;
    run_count(12, pulses);
    chk("glitch_pulses", 32'(pulses), 32'd0);
    chk("glitch_lamp", 32'(lamp), 32'h0);
    btn = 4'b0001;
    tick(3);
    btn = 4'b0000;
    run_count(12, pulses);
    chk("pulse3_pulses", 32'(pulses), 32'd1);
    chk("pulse3_num", 32'(playerNum), 32'd0);
    chk("pulse3_lamp", 32'(lamp), 32'h1);
    tick(20);
    chk("pulse3_lamp_off", 32'(lamp), 32'h0);

    // Simultaneous rises and rise while another pad held
    btn = 4'b1001;
    run_count(12, pulses);
    chk("dual_pulses", 32'(pulses), 32'd0);
    btn = 4'b0000;
    tick(10);
    btn = 4'b0010;
    run_count(8, pulses);
    chk("p1_pulses", 32'(pulses), 32'd1);
    btn = 4'b1010;
    run_count(10, pulses);
    chk("held_rise_pulses", 32'(pulses), 32'd0);
    chk("held_rise_num", 32'(playerNum), 32'd1);
    btn = 4'b0000;
    tick(25);
    chk("echo_done_lamp", 32'(lamp), 32'h0);

    // Core's turn: presses blocked, lamp mirrors the core
    simonTurn = 1'b1;
    tick(2);
    chk("turn_accepting", 32'(accepting), 32'd0);
    btn = 4'b0010;
    run_count(10, pulses);
    chk("turn_pulses", 32'(pulses), 32'd0);
    chk("show_dark", 32'(lamp), 32'h0);
    simonNum = 2'd3; simonPressed = 1'b1;
    tick(1);
    chk("show_lamp3", 32'(lamp), 32'h8);
    simonTurn = 1'b0; simonPressed = 1'b0;
    run_count(10, pulses);
    chk("held_across_turn", 32'(pulses), 32'd0);
    chk("after_turn_accepting", 32'(accepting), 32'd1);
    chk("after_turn_lamp", 32'(lamp), 32'h0);
    btn = 4'b0000;
    tick(8);

    // Button held through reset
    btn = 4'b0100;
    reset_n = 1'b0;
    tick(2);
    chk("rst2_num", 32'(playerNum), 32'd0);
    chk("rst2_lamp", 32'(lamp), 32'h0);
    reset_n = 1'b1;
    run_count(15, pulses);
    chk("held_rst_pulses", 32'(pulses), 32'd0);
    chk("held_rst_accepting", 32'(accepting), 32'd0);
    btn = 4'b0000;
    tick(10);
    chk("rearm_accepting", 32'(accepting), 32'd1);
    btn = 4'b0100;
    run_count(10, pulses);
    chk("rearm_pulses", 32'(pulses), 32'd1);
    chk("rearm_num", 32'(playerNum), 32'd2);
    btn = 4'b0000;
    tick(2);

    // Game over blink, presses ignored, asynchronous reset
    gameOver = 1'b1;
    tick(1);
    chk("over_first_on", 32'(lamp), 32'hF);
    tick(29);
    chk("over_last_on", 32'(lamp), 32'hF);
    tick(1);
    chk("over_first_off", 32'(lamp), 32'h0);
    chk("over_accepting", 32'(accepting), 32'd0);
    tick(29);
    chk("over_last_off", 32'(lamp), 32'h0);
    tick(1);
    chk("over_on_again", 32'(lamp), 32'hF);
    btn = 4'b0001;
    run_count(10, pulses);
    chk("over_pulses", 32'(pulses), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_lamp", 32'(lamp), 32'h0);
    chk("async_rst_num", 32'(playerNum), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
